// File: rtl/avmm_reg_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM register arbiter.
// The round-robin pick rule lives here so the picker and any checker agree on it.
package avmm_reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Data returned to a requester whose read was force-completed by the watchdog.
    localparam logic [7:0] READ_TIMEOUT_DATA = 8'h00;

    // A sole requester wins outright; on a tie the one not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/avmm_reg_arb_rr_arb2.sv
// Two-way combinational round-robin picker used by avmm_reg_arb.
module rr_arb2
    import avmm_reg_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    // Pick the next requester from the live requests and last winner.
    always_comb begin
        grant = rr_pick(req, last);
    end

endmodule

// File: rtl/avmm_reg_arb.sv
// Arbitrates the CPU bridge (requester 0) and the loop sequencer (requester 1)
// onto one register master: one transaction in flight, read routing, read watchdog.
module avmm_reg_arb
    import avmm_reg_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_TIMEOUT = 255
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_read,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    output logic [DATA_W-1:0] r0_readdata,
    output logic              r0_readdatavalid,

    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_read,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [DATA_W-1:0] r1_readdata,
    output logic              r1_readdatavalid,

    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    output logic              avm_m0_write,
    output logic [DATA_W-1:0] avm_m0_writedata,
    input  logic              avm_m0_waitrequest,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_readdatavalid,

    output logic              rd_timeout
);

    localparam logic [15:0]       TCNT_LAST = 16'(RD_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] TMO_DATA  = DATA_W'(READ_TIMEOUT_DATA);

    state_t      state_r, state_n;
    logic        grant_r, grant_n;
    logic        last_r, last_n;
    logic [15:0] tcnt_r, tcnt_n;

    logic [1:0]        req_s;
    logic              pick_s;
    logic [ADDR_W-1:0] g_addr_s;
    logic              g_read_s;
    logic              g_write_s;
    logic [DATA_W-1:0] g_wdata_s;
    logic              g_req_s;
    logic              tmo_hit_s;
    logic              rsp_valid_s;
    logic              rsp_tmo_s;
    logic [DATA_W-1:0] rsp_data_s;

    assign req_s     = {r1_read | r1_write, r0_read | r0_write};
    assign tmo_hit_s = (tcnt_r == TCNT_LAST);

    rr_arb2 u_rr_arb2 (
        .req   (req_s),
        .last  (last_r),
        .grant (pick_s)
    );

    // Select the command fields of the currently granted requester.
    always_comb begin
        if (grant_r) begin
            g_addr_s  = r1_address;
            g_read_s  = r1_read;
            g_write_s = r1_write;
            g_wdata_s = r1_writedata;
        end else begin
            g_addr_s  = r0_address;
            g_read_s  = r0_read;
            g_write_s = r0_write;
            g_wdata_s = r0_writedata;
        end
        g_req_s = g_read_s | g_write_s;
    end

    // Read response source: real slave data beats the watchdog on the same cycle.
    always_comb begin
        rsp_valid_s = 1'b0;
        rsp_tmo_s   = 1'b0;
        rsp_data_s  = {DATA_W{1'b0}};
        if (state_r == RDWAIT) begin
            if (avm_m0_readdatavalid) begin
                rsp_valid_s = 1'b1;
                rsp_data_s  = avm_m0_readdata;
            end else if (tmo_hit_s) begin
                rsp_valid_s = 1'b1;
                rsp_tmo_s   = 1'b1;
                rsp_data_s  = TMO_DATA;
            end else begin
                rsp_valid_s = 1'b0;
            end
        end else begin
            rsp_valid_s = 1'b0;
        end
    end

    // Master command, requester stall and response routing outputs.
    always_comb begin
        avm_m0_address   = {ADDR_W{1'b0}};
        avm_m0_read      = 1'b0;
        avm_m0_write     = 1'b0;
        avm_m0_writedata = {DATA_W{1'b0}};
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        case (state_r)
            GRANT: begin
                avm_m0_address   = g_addr_s;
                avm_m0_write     = g_write_s;
                // Read and write together is a write.
                avm_m0_read      = g_read_s & ~g_write_s;
                avm_m0_writedata = g_wdata_s;
                if (grant_r) begin
                    r1_waitrequest = avm_m0_waitrequest;
                end else begin
                    r0_waitrequest = avm_m0_waitrequest;
                end
            end
            IDLE, RDWAIT: begin
                avm_m0_read  = 1'b0;
                avm_m0_write = 1'b0;
            end
            default: begin
                avm_m0_read  = 1'b0;
                avm_m0_write = 1'b0;
            end
        endcase
        r0_readdatavalid = rsp_valid_s & ~grant_r;
        r1_readdatavalid = rsp_valid_s & grant_r;
        r0_readdata      = r0_readdatavalid ? rsp_data_s : {DATA_W{1'b0}};
        r1_readdata      = r1_readdatavalid ? rsp_data_s : {DATA_W{1'b0}};
        rd_timeout       = rsp_tmo_s;
    end

    // Next-state, grant, fairness and watchdog counter logic.
    always_comb begin
        state_n = state_r;
        grant_n = grant_r;
        last_n  = last_r;
        tcnt_n  = tcnt_r;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    grant_n = pick_s;
                    state_n = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (!g_req_s) begin
                    state_n = IDLE;
                end else if (!avm_m0_waitrequest) begin
                    last_n = grant_r;
                    if (g_write_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = RDWAIT;
                        tcnt_n  = 16'd0;
                    end
                end else begin
                    state_n = GRANT;
                end
            end
            RDWAIT: begin
                if (avm_m0_readdatavalid || tmo_hit_s) begin
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt_r + 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State registers; reset leaves requester 0 as the first tie winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            tcnt_r  <= 16'd0;
        end else begin
            state_r <= state_n;
            grant_r <= grant_n;
            last_r  <= last_n;
            tcnt_r  <= tcnt_n;
        end
    end

endmodule

// File: tb/tb_avmm_reg_arb.sv
// Scoreboard bench for avmm_reg_arb: directed requests, slave model with
// programmable stall/latency, and a monitor that checks every beat and response.
module tb_avmm_reg_arb;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [3:0] hold;
    } cmd_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } beat_t;

    typedef struct packed {
        logic       who;
        logic [7:0] data;
        logic       tmo;
    } rsp_t;

    logic       clk;
    logic       reset;
    logic [7:0] r0_address, r1_address, r0_writedata, r1_writedata;
    logic       r0_read, r0_write, r1_read, r1_write;
    logic       r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
    logic [7:0] r0_readdata, r1_readdata;
    logic [7:0] avm_m0_address, avm_m0_writedata, avm_m0_readdata;
    logic       avm_m0_read, avm_m0_write, avm_m0_waitrequest, avm_m0_readdatavalid;
    logic       rd_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int beat_cnt = 0, rsp_cnt = 0, beat_cyc = 0, rsp_cyc = 0;
    int issue_cnt0 = 0, issue_cyc0 = 0;
    int slv_wait = 0, slv_lat = 0;
    logic [7:0] slv_rdata = 8'h00;
    logic stray_req = 1'b0;

    cmd_t  cmd_q0[$];
    cmd_t  cmd_q1[$];
    beat_t exp_beat[$];
    rsp_t  exp_rsp[$];

    avmm_reg_arb #(.ADDR_W(8), .DATA_W(8), .RD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
        .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest),
        .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
        .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
        .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest),
        .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
        .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
        .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata),
        .avm_m0_waitrequest(avm_m0_waitrequest), .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_readdatavalid(avm_m0_readdatavalid), .rd_timeout(rd_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic cmd_t mk(input logic rd, input logic wr, input logic [7:0] a,
                                input logic [7:0] d, input logic [3:0] hold);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.data = d; c.hold = hold;
        return c;
    endfunction

    task automatic push_cmd(input int id, input cmd_t c);
        if (id == 0) cmd_q0.push_back(c);
        else         cmd_q1.push_back(c);
    endtask

    task automatic push_beat(input logic wr, input logic [7:0] a, input logic [7:0] d);
        beat_t b;
        b.wr = wr; b.addr = a; b.data = d;
        exp_beat.push_back(b);
    endtask

    task automatic push_rsp(input logic who, input logic [7:0] d, input logic tmo);
        rsp_t r;
        r.who = who; r.data = d; r.tmo = tmo;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_beats(input int target, input int budget);
        int n = 0;
        while (beat_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (beat_cnt < target) flag_fail("wait_beats_timeout");
    endtask

    task automatic wait_rsps(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (rsp_cnt < target) flag_fail("wait_rsp_timeout");
    endtask

    // Requester agents: hold a command until accepted (or until its hold limit).
    initial begin : requesters
        cmd_t c0, c1;
        logic act0, act1, acc0, acc1;
        int   held0, held1;
        act0 = 1'b0; act1 = 1'b0; held0 = 0; held1 = 0;
        c0 = '0; c1 = '0;
        r0_read = 1'b0; r0_write = 1'b0; r0_address = 8'h00; r0_writedata = 8'h00;
        r1_read = 1'b0; r1_write = 1'b0; r1_address = 8'h00; r1_writedata = 8'h00;
        forever begin
            @(negedge clk);
            acc0 = act0 && !r0_waitrequest;
            acc1 = act1 && !r1_waitrequest;
            @(posedge clk); #1;
            if (act0) begin
                held0++;
                if (acc0) act0 = 1'b0;
                else if (c0.hold != 4'd0 && held0 >= int'(c0.hold)) act0 = 1'b0;
                else if (held0 > 200) begin flag_fail("r0_accept_timeout"); act0 = 1'b0; end
            end
            if (!act0 && cmd_q0.size() > 0) begin
                c0 = cmd_q0.pop_front(); act0 = 1'b1; held0 = 0;
                issue_cyc0 = cyc; issue_cnt0++;
            end
            if (act1) begin
                held1++;
                if (acc1) act1 = 1'b0;
                else if (c1.hold != 4'd0 && held1 >= int'(c1.hold)) act1 = 1'b0;
                else if (held1 > 200) begin flag_fail("r1_accept_timeout"); act1 = 1'b0; end
            end
            if (!act1 && cmd_q1.size() > 0) begin
                c1 = cmd_q1.pop_front(); act1 = 1'b1; held1 = 0;
            end
            r0_read = act0 & c0.rd; r0_write = act0 & c0.wr;
            r0_address = c0.addr;   r0_writedata = c0.data;
            r1_read = act1 & c1.rd; r1_write = act1 & c1.wr;
            r1_address = c1.addr;   r1_writedata = c1.data;
        end
    end

    // Slave model: programmable stall per command and read latency (0 = never).
    initial begin : slave
        int wcnt, pend;
        wcnt = 0; pend = 0;
        avm_m0_waitrequest = 1'b1; avm_m0_readdatavalid = 1'b0; avm_m0_readdata = 8'hEE;
        forever begin
            @(posedge clk); #2;
            avm_m0_readdatavalid = 1'b0;
            avm_m0_readdata      = 8'hEE;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avm_m0_readdatavalid = 1'b1;
                    avm_m0_readdata      = slv_rdata;
                end
            end
            if (stray_req) begin
                avm_m0_readdatavalid = 1'b1;
                avm_m0_readdata      = 8'h77;
                stray_req            = 1'b0;
            end
            if (avm_m0_read || avm_m0_write) begin
                if (wcnt < slv_wait) begin
                    avm_m0_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    avm_m0_waitrequest = 1'b0;
                    wcnt = 0;
                    if (avm_m0_read && slv_lat > 0) pend = slv_lat;
                end
            end else begin
                avm_m0_waitrequest = 1'b1;
                wcnt = 0;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT issues a beat or a response.
    initial begin : monitor
        beat_t eb;
        rsp_t  er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if ((avm_m0_read || avm_m0_write) && !avm_m0_waitrequest) begin
                    beat_cnt++; beat_cyc = cyc;
                    if (exp_beat.size() == 0) begin
                        flag_fail("beat_unexpected");
                    end else begin
                        eb = exp_beat.pop_front();
                        chk("beat_rw", {30'd0, avm_m0_read, avm_m0_write}, {30'd0, ~eb.wr, eb.wr});
                        chk("beat_addr", 32'(avm_m0_address), 32'(eb.addr));
                        if (eb.wr) chk("beat_wdata", 32'(avm_m0_writedata), 32'(eb.data));
                    end
                end
                if (r0_readdatavalid || r1_readdatavalid) begin
                    rsp_cnt++; rsp_cyc = cyc;
                    if (exp_rsp.size() == 0) begin
                        flag_fail("rsp_unexpected");
                    end else begin
                        er = exp_rsp.pop_front();
                        chk("rsp_both", 32'(r0_readdatavalid & r1_readdatavalid), 32'd0);
                        chk("rsp_who", 32'(r1_readdatavalid), 32'(er.who));
                        chk("rsp_data", 32'(er.who ? r1_readdata : r0_readdata), 32'(er.data));
                        chk("rsp_other_zero", 32'(er.who ? r0_readdata : r1_readdata), 32'd0);
                        chk("rsp_tmo", 32'(rd_timeout), 32'(er.tmo));
                    end
                end else if (rd_timeout) begin
                    flag_fail("tmo_without_valid");
                end
                if (!r0_waitrequest || !r1_waitrequest)
                    chk("wr_exclusive", 32'(r0_waitrequest | r1_waitrequest), 32'd1);
            end
        end
    end

    initial begin : main
        int n, t0, b0;
        logic seen;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r0_wait", 32'(r0_waitrequest), 32'd1);
        chk("rst_r1_wait", 32'(r1_waitrequest), 32'd1);
        chk("rst_master", {22'd0, avm_m0_read, avm_m0_write, avm_m0_address}, 32'd0);
        chk("rst_wdata", 32'(avm_m0_writedata), 32'd0);
        chk("rst_rdv_tmo", {29'd0, r0_readdatavalid, r1_readdatavalid, rd_timeout}, 32'd0);

        // Both requesters write continuously from reset: grants 0,1,0,1.
        push_beat(1'b1, 8'h10, 8'h01); push_beat(1'b1, 8'h20, 8'h11);
        push_beat(1'b1, 8'h11, 8'h02); push_beat(1'b1, 8'h21, 8'h12);
        push_cmd(0, mk(1'b0, 1'b1, 8'h10, 8'h01, 4'd0));
        push_cmd(0, mk(1'b0, 1'b1, 8'h11, 8'h02, 4'd0));
        push_cmd(1, mk(1'b0, 1'b1, 8'h20, 8'h11, 4'd0));
        push_cmd(1, mk(1'b0, 1'b1, 8'h21, 8'h12, 4'd0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_beats(4, 40);
        repeat (2) @(negedge clk);

        // Single write with two slave stall cycles.
        slv_wait = 2;
        t0 = issue_cnt0;
        push_beat(1'b1, 8'h12, 8'hA5);
        push_cmd(0, mk(1'b0, 1'b1, 8'h12, 8'hA5, 4'd0));
        n = 0;
        while (issue_cnt0 == t0 && n < 20) begin @(negedge clk); #1; n++; end
        if (issue_cnt0 == t0) flag_fail("sw_issue_timeout");
        @(negedge clk);
        chk("sw_n1_cycle", 32'(cyc - issue_cyc0), 32'd1);
        chk("sw_n1_addr", 32'(avm_m0_address), 32'h12);
        chk("sw_n1_wdata", 32'(avm_m0_writedata), 32'hA5);
        chk("sw_n1_write", 32'(avm_m0_write), 32'd1);
        chk("sw_n1_wait", 32'(r0_waitrequest), 32'd1);
        @(negedge clk);
        chk("sw_n2_wait", 32'(r0_waitrequest), 32'd1);
        @(negedge clk);
        chk("sw_n3_wait", 32'(r0_waitrequest), 32'd0);
        wait_beats(5, 20);
        chk("sw_beat_cycle", 32'(beat_cyc - issue_cyc0), 32'd3);
        slv_wait = 0;
        repeat (3) @(negedge clk);

        // Read and write asserted together is issued as a write.
        push_beat(1'b1, 8'h13, 8'h5C);
        push_cmd(0, mk(1'b1, 1'b1, 8'h13, 8'h5C, 4'd0));
        wait_beats(6, 20);
        repeat (2) @(negedge clk);

        // Requester withdraws before accept: nothing reaches the slave.
        slv_wait = 5;
        b0 = beat_cnt;
        push_cmd(1, mk(1'b0, 1'b1, 8'h22, 8'h33, 4'd2));
        repeat (8) @(negedge clk);
        chk("drop_no_beat", 32'(beat_cnt), 32'(b0));
        chk("drop_idle_master", {30'd0, avm_m0_read, avm_m0_write}, 32'd0);
        slv_wait = 0;

        // Read routing to requester 1, slave answers after 4 cycles.
        slv_lat = 4; slv_rdata = 8'h3C;
        push_beat(1'b0, 8'h40, 8'h00);
        push_rsp(1'b1, 8'h3C, 1'b0);
        push_cmd(1, mk(1'b1, 1'b0, 8'h40, 8'h00, 4'd0));
        wait_rsps(1, 40);
        chk("rd_latency", 32'(rsp_cyc - beat_cyc), 32'd4);
        repeat (2) @(negedge clk);

        // Slave never answers: watchdog completes 8 cycles after accept.
        slv_lat = 0;
        push_beat(1'b0, 8'h30, 8'h00);
        push_rsp(1'b0, 8'h00, 1'b1);
        push_cmd(0, mk(1'b1, 1'b0, 8'h30, 8'h00, 4'd0));
        wait_rsps(2, 50);
        chk("tmo_latency", 32'(rsp_cyc - beat_cyc), 32'd8);
        stray_req = 1'b1;
        @(negedge clk);
        chk("stray_present", 32'(avm_m0_readdatavalid), 32'd1);
        chk("stray_dropped", {30'd0, r0_readdatavalid, r1_readdatavalid}, 32'd0);
        repeat (2) @(negedge clk);

        // Real data arriving on the watchdog cycle wins, no timeout pulse.
        slv_lat = 8; slv_rdata = 8'h5A;
        push_beat(1'b0, 8'h31, 8'h00);
        push_rsp(1'b1, 8'h5A, 1'b0);
        push_cmd(1, mk(1'b1, 1'b0, 8'h31, 8'h00, 4'd0));
        wait_rsps(3, 50);
        chk("edge_latency", 32'(rsp_cyc - beat_cyc), 32'd8);
        repeat (2) @(negedge clk);

        // Reset while waiting for read data; late data must be dropped.
        slv_lat = 6; slv_rdata = 8'h99;
        b0 = beat_cnt;
        push_beat(1'b0, 8'h55, 8'h00);
        push_cmd(0, mk(1'b1, 1'b0, 8'h55, 8'h00, 4'd0));
        wait_beats(b0 + 1, 20);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wait", {30'd0, r0_waitrequest, r1_waitrequest}, 32'd3);
        @(posedge clk); #1 reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (avm_m0_readdatavalid) begin
                seen = 1'b1;
                chk("late_rsp_dropped", {30'd0, r0_readdatavalid, r1_readdatavalid}, 32'd0);
            end
        end
        chk("late_rsp_seen", 32'(seen), 32'd1);
        chk("post_rst_idle", {22'd0, avm_m0_read, avm_m0_write, avm_m0_address}, 32'd0);
        slv_lat = 0;
        b0 = beat_cnt;
        push_beat(1'b1, 8'h60, 8'hB1); push_beat(1'b1, 8'h61, 8'hB2);
        push_cmd(0, mk(1'b0, 1'b1, 8'h60, 8'hB1, 4'd0));
        push_cmd(1, mk(1'b0, 1'b1, 8'h61, 8'hB2, 4'd0));
        wait_beats(b0 + 2, 30);
        repeat (4) @(negedge clk);

        chk("beats_left", 32'(exp_beat.size()), 32'd0);
        chk("rsps_left", 32'(exp_rsp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avmm_reg_arb.md
Name: avmm_reg_arb

Overview:
- Two-requester arbiter for the 8-bit Avalon-MM register master port (avm_m0_*) of the lms_ctr system.
- Lets the CPU-side bridge (requester 0) and the hardware GPSDO/VCTCXO loop sequencer (requester 1) share one register bus.
- Round-robin grant, one transaction in flight, read-response routing, and a read-timeout watchdog so a dead slave cannot hang a requester.

Parameters:
- ADDR_W, 8, address width of requesters and master.
- DATA_W, 8, read/write data width.
- RD_TIMEOUT, 255, cycles allowed in RDWAIT before a forced response; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_address  in  ADDR_W  requester 0 address.
- r0_read  in  1  requester 0 read request.
- r0_write  in  1  requester 0 write request.
- r0_writedata  in  DATA_W  requester 0 write data.
- r0_waitrequest  out  1  requester 0 stall.
- r0_readdata  out  DATA_W  requester 0 read data.
- r0_readdatavalid  out  1  requester 0 read data strobe.
- r1_* (address, read, write, writedata, waitrequest, readdata, readdatavalid): identical set for requester 1.
- avm_m0_address  out  ADDR_W  master address.
- avm_m0_read  out  1  master read.
- avm_m0_write  out  1  master write.
- avm_m0_writedata  out  DATA_W  master write data.
- avm_m0_waitrequest  in  1  slave stall.
- avm_m0_readdata  in  DATA_W  slave read data.
- avm_m0_readdatavalid  in  1  slave read data strobe.
- rd_timeout  out  1  one-cycle pulse when a read is force-completed.

Behaviour:
- States: IDLE, GRANT, RDWAIT.
- Registers:
  - state.
  - grant (1 bit).
  - last (1 bit, last requester served).
  - tcnt (16 bits).
- Reset: state=IDLE, grant=0, last=1 (requester 0 wins first tie), tcnt=0.
  - All master outputs 0; rd_timeout=0; both readdatavalid=0; both waitrequest=1.
- Request definition: req_n = rn_read | rn_write.
- IDLE:
  - No requester sees waitrequest low.
  - Master outputs 0.
  - Stray avm_m0_readdatavalid is discarded.
  - If any req_n: grant <= sole requester; if both, grant <= ~last. Go to GRANT next cycle.
- GRANT:
  - Master address/read/write/writedata mux combinationally from the granted requester.
  - If the requester asserts read and write together, it is treated as a write: avm_m0_read is forced 0.
  - Granted waitrequest = avm_m0_waitrequest. Non-granted waitrequest = 1.
  - Accept is the cycle with req & !avm_m0_waitrequest:
    - last <= grant.
    - Write accept -> IDLE.
    - Read accept -> RDWAIT, tcnt <= 0.
  - If the granted requester drops req before accept, go to IDLE with no transaction issued.
- RDWAIT:
  - Master read/write = 0; both waitrequest = 1.
  - avm_m0_readdatavalid: granted rn_readdatavalid=1 and rn_readdata=avm_m0_readdata, same cycle (combinational); -> IDLE.
  - Otherwise tcnt++. When tcnt==RD_TIMEOUT-1 with no valid:
    - granted readdatavalid=1, readdata=0x00.
    - rd_timeout=1 for that cycle.
    - -> IDLE.
  - A valid arriving on the timeout cycle takes priority: real data, no rd_timeout pulse.
- Readdata of a non-strobed requester is 0.
- Minimum latency: request seen in cycle N gives master command in N+1. Back-to-back transactions need one IDLE cycle between grants.
- Reset mid-transaction returns to IDLE immediately. A late slave response after reset is dropped in IDLE.

Decomposition:
- Package avmm_reg_arb_pkg holds:
  - state enum (IDLE, GRANT, RDWAIT).
  - ADDR_W/DATA_W defaults.
  - READ_TIMEOUT_DATA = 8'h00.
- Sub-module rr_arb2: 2-way round-robin picker with inputs req[1:0] and last, output grant. Combinational, instantiated once.
- All other logic is in the top module.

Test Plan:
- Single write: r0_write, addr 0x12, data 0xA5, slave waitrequest 2 cycles -> master shows 0x12/0xA5 from cycle N+1; r0_waitrequest drops on cycle N+3; exactly one write beat.
- Tie and round-robin: r0 and r1 both write continuously from reset -> grant order 0,1,0,1; each master beat carries the correct writedata; non-granted waitrequest stays 1.
- Read routing: r1 reads 0x40, slave returns 0x3C after 4 cycles -> r1_readdatavalid pulses once with 0x3C; r0_readdatavalid stays 0.
- Timeout: RD_TIMEOUT=8, r0 reads and the slave never responds -> 8 cycles after accept, r0_readdatavalid=1, readdata=0x00, rd_timeout pulse; a later stray slave valid is ignored.
- Valid on the timeout cycle: slave valid arrives exactly on cycle RD_TIMEOUT-1 -> real data delivered, no rd_timeout pulse.
- Reset in RDWAIT: assert reset 1 cycle, then the slave valid arrives -> no readdatavalid to either requester; state is IDLE; next r0 request granted first.
